// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the future receiver.
//   uart_state_t   - frame sequencer state (IDLE, START, DATA, STOP)
//   UART_DATA_BITS - payload bits per frame (8N1)
//   UART_BAUD_DIV  - default clocks per bit (50 MHz / 115200)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BAUD_DIV  = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART sequencer.
//   clkIN    in  system clock, rising edge
//   nResetIN in  async active-low reset
//   clearIN  in  hold the count at 0 (restarts the bit period)
//   tickOUT  out one-clock strobe while the count sits at BAUD_DIV-1;
//                the following edge is the bit boundary
module uart_baud_gen #(
  parameter int BAUD_DIV = 434
) (
  input  logic clkIN,
  input  logic nResetIN,
  input  logic clearIN,
  output logic tickOUT
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // Wraps to 0 on the boundary edge itself, so each bit is exactly
  // BAUD_DIV clocks with no accumulated drift.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN)                     cnt <= '0;
    else if (clearIN || cnt == LAST)   cnt <= '0;
    else                               cnt <= cnt + CW'(1);
  end

  assign tickOUT = (cnt == LAST) && !clearIN;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter behind the send-request handshake.
//   clkIN    in  system clock, rising edge
//   nResetIN in  async active-low reset
//   sendIN   in  frame request, level, sampled only in IDLE
//   dataIN   in  byte to send, captured on the accepting edge
//   txOUT    out serial line, idle high, registered
//   nBusyOUT out 1 = ready, 0 = frame in progress, registered
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = UART_BAUD_DIV,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clkIN,
  input  logic                 nResetIN,
  input  logic                 sendIN,
  input  logic [DATA_BITS-1:0] dataIN,
  output logic                 txOUT,
  output logic                 nBusyOUT
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic                 tx, tx_nxt;
  logic                 busy_n, busy_n_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic                 tick;
  logic                 baud_clr;

  // Timer is parked at 0 in IDLE so the start bit gets a full period
  // measured from the accepting edge.
  assign baud_clr = (state == IDLE);

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clkIN    (clkIN),
    .nResetIN (nResetIN),
    .clearIN  (baud_clr),
    .tickOUT  (tick)
  );

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy_n  <= 1'b1;
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tx      <= tx_nxt;
      busy_n  <= busy_n_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  // Outputs are computed one cycle ahead and registered, so the line
  // changes exactly on the bit-boundary edge.
  always_comb begin
    state_nxt  = state;
    tx_nxt     = tx;
    busy_n_nxt = busy_n;
    shift_nxt  = shift;
    bit_nxt    = bit_cnt;
    case (state)
      IDLE: begin
        tx_nxt     = 1'b1;
        busy_n_nxt = 1'b1;
        if (sendIN) begin
          shift_nxt  = dataIN;
          state_nxt  = START;
          tx_nxt     = 1'b0;
          busy_n_nxt = 1'b0;
        end
      end
      START: if (tick) begin
        state_nxt = DATA;
        tx_nxt    = shift[0];
        bit_nxt   = '0;
      end
      DATA: if (tick) begin
        if (bit_cnt == LAST_BIT) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end else begin
          // shift[1] is the bit that lands in shift[0] after this shift
          shift_nxt = shift >> 1;
          bit_nxt   = bit_cnt + BW'(1);
          tx_nxt    = shift[1];
        end
      end
      STOP: if (tick) begin
        state_nxt  = IDLE;
        tx_nxt     = 1'b1;
        busy_n_nxt = 1'b1;
      end
      default: begin
        state_nxt  = IDLE;
        tx_nxt     = 1'b1;
        busy_n_nxt = 1'b1;
      end
    endcase
  end

  assign txOUT    = tx;
  assign nBusyOUT = busy_n;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with BAUD_DIV = 4.
// Inputs change 1-2 time units after a rising edge; outputs are sampled
// at +1 after the rising edge, well clear of the next edge.
module tb_uart_tx;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send;
  logic [7:0] data;
  logic       tx;
  logic       busy_n;

  int total = 0;
  int bad   = 0;

  uart_tx #(.BAUD_DIV(BD)) dut (
    .clkIN    (clk),
    .nResetIN (rst_n),
    .sendIN   (send),
    .dataIN   (data),
    .txOUT    (tx),
    .nBusyOUT (busy_n)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Call at +1 after the accepting edge k. Collects one bit per slot,
  // counts clocks whose value disagrees with the slot's first clock,
  // and counts busy-low clocks. Returns at +1 after edge k+10*BD.
  task automatic run_frame(output logic [9:0] bits, output int busy_low, output int glitch);
    bits = '0; busy_low = 0; glitch = 0;
    for (int j = 0; j < 10*BD; j++) begin
      if (j % BD == 0) bits[j/BD] = tx;
      else if (tx !== bits[j/BD]) glitch++;
      if (busy_n !== 1'b1) busy_low++;
      tick1();
    end
  endtask

  logic [9:0] fb;
  int bl, gl, n;

  initial begin
    rst_n = 1'b0; send = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy_n, 1);
    rst_n = 1'b1;
    tick1();

    // single frame, 0xA5
    send = 1'b1; data = 8'hA5;
    tick1();
    send = 1'b0;
    run_frame(fb, bl, gl);
    chk("a5_frame", fb, 10'h34A);
    chk("a5_busy_low", bl, 40);
    chk("a5_glitch", gl, 0);
    chk("a5_busy_end", busy_n, 1);
    chk("a5_tx_end", tx, 1);
    tick1();
    chk("a5_idle_busy", busy_n, 1);

    // handshake: hold send until busy falls
    send = 1'b1; data = 8'h00;
    n = 0;
    while (busy_n === 1'b1 && n < 5) begin
      tick1();
      n++;
    end
    send = 1'b0;
    chk("hs_latency", n, 1);
    run_frame(fb, bl, gl);
    chk("hs_frame", fb, 10'h200);
    chk("hs_busy_low", bl, 40);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy_n !== 1'b1 || tx !== 1'b1) n++;
      tick1();
    end
    chk("hs_one_frame", n, 0);

    // back-to-back: send held high across two frames
    send = 1'b1; data = 8'h55;
    tick1();
    data = 8'hFF;
    run_frame(fb, bl, gl);
    chk("b2b_f1", fb, 10'h2AA);
    chk("b2b_f1_glitch", gl, 0);
    chk("b2b_gap_busy", busy_n, 1);
    chk("b2b_gap_tx", tx, 1);
    tick1();
    send = 1'b0;
    run_frame(fb, bl, gl);
    chk("b2b_f2", fb, 10'h3FE);
    chk("b2b_f2_busy_low", bl, 40);
    chk("b2b_f2_glitch", gl, 0);

    // data stability: dataIN changes two clocks after acceptance
    tick1();
    send = 1'b1; data = 8'h3C;
    tick1();
    send = 1'b0;
    fork
      run_frame(fb, bl, gl);
      begin
        repeat (2) @(posedge clk);
        #2 data = 8'hC3;
      end
    join
    chk("stab_frame", fb, 10'h278);

    // reset during data bit 3 (begins at k+16)
    tick1();
    send = 1'b1; data = 8'h00;
    tick1();
    send = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("mid_tx_pre", tx, 0);
    chk("mid_busy_pre", busy_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy_n, 1);
    // request present while reset is held: must not start
    send = 1'b1; data = 8'h81;
    tick1();
    chk("rst_send_busy", busy_n, 1);
    rst_n = 1'b1;
    tick1();
    send = 1'b0;
    run_frame(fb, bl, gl);
    chk("post_rst_frame", fb, 10'h302);
    chk("post_rst_busy_low", bl, 40);

    // request pulsed during STOP is ignored
    tick1();
    send = 1'b1; data = 8'hA5;
    tick1();
    send = 1'b0;
    fork
      run_frame(fb, bl, gl);
      begin
        repeat (37) @(posedge clk);
        #2 send = 1'b1;
        @(posedge clk);
        #2 send = 1'b0;
      end
    join
    chk("ign_frame", fb, 10'h34A);
    chk("ign_busy_low", bl, 40);
    chk("ign_busy_end", busy_n, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy_n !== 1'b1 || tx !== 1'b1) n++;
      tick1();
    end
    chk("ign_idle", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that consumes the `sendOUT`/`nBusyIN` handshake produced by the send-request stage and shifts one 8N1 UART frame (start bit, 8 data bits LSB first, one stop bit) onto `txOUT`. It sits directly downstream of the send-request generator. Its `nBusyOUT` feeds that stage's `nBusyIN`, and `txOUT` drives the pin.

## Interface
- `BAUD_DIV`, 434: clocks per bit period (50 MHz / 115200). Legal range 2..65535.
- `DATA_BITS`, 8: payload bits per frame. Fixed at 8 for this release.

Ports:
- `clkIN`  in  1  system clock, rising-edge.
- `nResetIN`  in  1  asynchronous, active-low reset.
- `sendIN`  in  1  frame request, level-sensitive, sampled only in IDLE.
- `dataIN`  in  8  byte to send, captured on the accepting edge.
- `txOUT`  out  1  serial line, idle-high.
- `nBusyOUT`  out  1  1 = idle and ready; 0 = frame in progress.

## Operation
- Reset (async assert, sync-to-clock deassert handled upstream):
  - state = IDLE, `txOUT` = 1, `nBusyOUT` = 1.
  - Bit counter = 0, baud counter = 0, shift register = 0.
- States are IDLE → START → DATA → STOP → IDLE.
- **IDLE:** `txOUT` = 1 and `nBusyOUT` = 1. If `sendIN` = 1 at a rising edge:
  - latch `dataIN` into the shift register;
  - go to START, set `txOUT` = 0 and `nBusyOUT` = 0;
  - clear the baud counter.
- **START:** hold `txOUT` = 0 for `BAUD_DIV` clocks, then go to DATA with `txOUT` = shift[0] and bit counter = 0.
- **DATA:** each bit is held for `BAUD_DIV` clocks.
  - At each bit boundary, shift right and increment the bit counter.
  - After bit 7 completes, go to STOP with `txOUT` = 1.
- **STOP:** hold `txOUT` = 1 for `BAUD_DIV` clocks, then go to IDLE with `nBusyOUT` = 1.
- `sendIN` is ignored outside IDLE. `dataIN` changes after the accepting edge have no effect.
- Upstream must drop `sendIN` after seeing `nBusyOUT` = 0. If `sendIN` is still 1 on the first IDLE cycle, a new frame starts (back-to-back).
- Baud counter width is `$clog2(BAUD_DIV)`. It counts 0..`BAUD_DIV`-1 and wraps to 0 at each bit boundary with no drift.
- `txOUT` and `nBusyOUT` are registered outputs with no combinational path from any input.

## Timing
- Accept latency: `sendIN` high at edge k → `txOUT` = 0 and `nBusyOUT` = 0 after edge k.
- Bit edges:
  - start bit spans edges k..k+`BAUD_DIV`;
  - data bit n begins at edge k+(n+1)·`BAUD_DIV`;
  - stop bit begins at edge k+9·`BAUD_DIV`.
- `nBusyOUT` returns to 1 at edge k+10·`BAUD_DIV` and stays 1 for at least one full clock.
- Back-to-back frame period is 10·`BAUD_DIV`+1 clocks.
- Reset mid-frame: `txOUT` = 1 and `nBusyOUT` = 1 immediately and asynchronously. The partial frame is abandoned, and the first post-reset edge is IDLE.
- `sendIN` and reset deassertion in the same cycle: no frame starts until the first edge with `nResetIN` = 1 and `sendIN` = 1.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS` = 8;
  - the default `BAUD_DIV` constant, reused by the future `uart_rx`.
- One sub-module, `uart_baud_gen`:
  - parameter `BAUD_DIV`;
  - inputs `clkIN`, `nResetIN`, `clearIN`;
  - output `tickOUT`, a one-clock pulse when the count reaches `BAUD_DIV`-1.
  - The FSM uses `tickOUT` as its bit-boundary strobe.

## Test plan
All scenarios use `BAUD_DIV` = 4.
- **Single frame:** after reset, pulse `sendIN` for 1 clock with `dataIN` = 0xA5.
  - `txOUT` sequence per 4-clock slot: 0,1,0,1,0,0,1,0,1,1.
  - `nBusyOUT` is low for exactly 40 clocks.
- **Handshake with the send-request stage:** hold `sendIN` high until `nBusyOUT` falls, with `dataIN` = 0x00.
  - Exactly one frame is sent.
  - `nBusyOUT` falls one edge after `sendIN` is seen high.
- **Back-to-back:** hold `sendIN` = 1 continuously with `dataIN` = 0x55 then 0xFF.
  - Frames start 41 clocks apart.
  - The stop bit is high for a full 4 clocks before the next start bit.
- **Data stability:** change `dataIN` from 0x3C to 0xC3 two clocks after acceptance.
  - The transmitted payload is 0x3C.
- **Reset mid-frame:** assert `nResetIN` = 0 during data bit 3.
  - `txOUT` = 1 and `nBusyOUT` = 1 before the next edge.
  - After release, a new frame with 0x81 transmits correctly.
- **Ignored request:** pulse `sendIN` during STOP.
  - No new frame starts.
  - `nBusyOUT` rises on schedule and the line stays idle-high.
